fetch_byte_queue: RTL and testbench

- Producer end of the fetch→decode byte-stream interface.
- Accepts aligned 16-byte instruction lines from the instruction-memory side and buffers up to DEPTH lines.
- Presents a byte-aligned window of up to 32 bytes, starting at the current PC, to decode_top.
- Advances by the byte count the decoder reports consumed. On flush, the queue is cleared and restarts at a redirect PC.

---
 rtl/fetch_pkg.sv | 13 +
 rtl/fetch_byte_queue_if.sv | 32 +++
 rtl/fetch_byte_queue_window_align.sv | 27 ++
 rtl/fetch_byte_queue.sv | 111 +++++++++++
 tb/tb_fetch_byte_queue.sv | 201 ++++++++++++++++++++
 5 files changed

// File: rtl/fetch_pkg.sv
// fetch_pkg: constants shared by the fetch byte queue and decode_top.
//   LINE_BYTES/LINE_W     : one aligned instruction line (16 bytes).
//   WINDOW_BYTES/WINDOW_W : the byte window presented to the decoder (32 bytes).
//   CNT_W                 : width of byte counts on the fetch interface (0..32).
//   OFFS_W                : width of a byte index inside one line.
package fetch_pkg;
    localparam int LINE_BYTES   = 16;
    localparam int WINDOW_BYTES = 32;
    localparam int LINE_W       = LINE_BYTES * 8;
    localparam int WINDOW_W     = WINDOW_BYTES * 8;
    localparam int CNT_W        = 6;
    localparam int OFFS_W       = 4;
endpackage

// File: rtl/fetch_byte_queue_if.sv
// Handshake bundles around the fetch byte queue.
//   line_if  : instruction-memory side. master = line source, slave = queue.
//              l_valid/l_ready handshake, l_data line bytes, l_branch_taken flag.
//   fetch_if : decoder side. master = queue, slave = decode_top.
//              f_valid/f_ready handshake, f_bytes_read consumed count,
//              f_valid_bytes/f_instruction window, f_pc, f_branch_taken.
interface line_if #(parameter int IDATAW = 128);
    logic              l_valid;
    logic              l_ready;
    logic [IDATAW-1:0] l_data;
    logic              l_branch_taken;

    modport master (output l_valid, l_data, l_branch_taken, input l_ready);
    modport slave  (input l_valid, l_data, l_branch_taken, output l_ready);
endinterface

interface fetch_if
    import fetch_pkg::*;
#(parameter int IADDRW = 32);
    logic                f_valid;
    logic                f_ready;
    logic [CNT_W-1:0]    f_bytes_read;
    logic [CNT_W-1:0]    f_valid_bytes;
    logic [WINDOW_W-1:0] f_instruction;
    logic [IADDRW-1:0]   f_pc;
    logic                f_branch_taken;

    modport master (output f_valid, f_valid_bytes, f_instruction, f_pc, f_branch_taken,
                    input  f_ready, f_bytes_read);
    modport slave  (input  f_valid, f_valid_bytes, f_instruction, f_pc, f_branch_taken,
                    output f_ready, f_bytes_read);
endinterface

// File: rtl/fetch_byte_queue_window_align.sv
// fetch_window_align: combinational window builder.
//   line0..line2 : head line and the two following lines (already zeroed if absent)
//   offset       : byte index of the window start inside line0
//   win_bytes    : number of valid window bytes (0..32)
//   window       : 32-byte window, bytes at or beyond win_bytes forced to zero
module fetch_window_align
    import fetch_pkg::*;
(
    input  logic [LINE_W-1:0]   line0,
    input  logic [LINE_W-1:0]   line1,
    input  logic [LINE_W-1:0]   line2,
    input  logic [OFFS_W-1:0]   offset,
    input  logic [CNT_W-1:0]    win_bytes,
    output logic [WINDOW_W-1:0] window
);
    logic [3*LINE_W-1:0] cat;
    logic [WINDOW_W-1:0] shifted;

    always_comb begin
        cat     = {line2, line1, line0};
        shifted = WINDOW_W'(cat >> {offset, 3'b000});
        window  = '0;
        for (int i = 0; i < WINDOW_BYTES; i++) begin
            if (i < int'(win_bytes)) window[8*i +: 8] = shifted[8*i +: 8];
        end
    end
endmodule

// File: rtl/fetch_byte_queue.sv
// fetch_byte_queue: buffers aligned 16-byte lines and presents a byte-aligned
// window of up to 32 bytes starting at the current PC to the decoder.
//   clk, reset          : clock and asynchronous active-high reset
//   flush, redirect_pc  : drop all buffered bytes and restart at redirect_pc
//   line  (line_if)     : incoming lines from instruction memory
//   fetch (fetch_if)    : window, PC and consume handshake towards decode_top
module fetch_byte_queue
    import fetch_pkg::*;
#(
    parameter int                IDATAW   = 128,
    parameter int                IADDRW   = 32,
    parameter int                DEPTH    = 4,
    parameter logic [IADDRW-1:0] RESET_PC = '0
)(
    input  logic              clk,
    input  logic              reset,
    input  logic              flush,
    input  logic [IADDRW-1:0] redirect_pc,
    line_if.slave             line,
    fetch_if.master           fetch
);
    localparam int PTR_W  = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CNT_LW = $clog2(DEPTH + 1);

    logic [IDATAW-1:0] ram [DEPTH];
    logic              bt  [DEPTH];
    logic [PTR_W-1:0]  head, tail;
    logic [CNT_LW-1:0] count;
    logic [OFFS_W-1:0] offset;
    logic [IADDRW-1:0] pc;

    logic [IDATAW-1:0] lines [3];
    int                avail;
    logic [CNT_W-1:0]  win_bytes;
    logic              l_ready_i, push, handshake, legal, consume;
    logic [CNT_W-1:0]  sum;
    logic [CNT_LW-1:0] pops;

    function automatic logic [PTR_W-1:0] ptr_add(input logic [PTR_W-1:0] p, input int n);
        return PTR_W'((int'(p) + n) % DEPTH);
    endfunction

    always_comb begin
        for (int k = 0; k < 3; k++) begin
            lines[k] = (k < int'(count)) ? ram[ptr_add(head, k)] : '0;
        end
        // offset may be non-zero with an empty queue right after a flush
        avail     = (count == '0) ? 0 : LINE_BYTES * int'(count) - int'(offset);
        win_bytes = (avail > WINDOW_BYTES) ? CNT_W'(WINDOW_BYTES) : CNT_W'(avail);
    end

    assign l_ready_i = !reset && !flush && (int'(count) < DEPTH);
    assign push      = line.l_valid && l_ready_i;
    assign handshake = fetch.f_valid && fetch.f_ready;
    assign legal     = (fetch.f_bytes_read != '0) && (fetch.f_bytes_read <= win_bytes);
    assign consume   = handshake && legal;

    // bytes_read <= avail bounds sum>>4 by count; the clamp only guards illegal input
    always_comb begin
        sum  = CNT_W'(offset) + fetch.f_bytes_read;
        pops = (CNT_LW'(sum[5:4]) > count) ? count : CNT_LW'(sum[5:4]);
        if (!consume) pops = '0;
    end

    always_ff @(posedge clk) begin
        if (push) begin
            ram[tail] <= line.l_data;
            bt[tail]  <= line.l_branch_taken;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            count  <= '0;
            head   <= '0;
            tail   <= '0;
            offset <= '0;
            pc     <= RESET_PC;
        end else if (flush) begin
            count  <= '0;
            head   <= '0;
            tail   <= '0;
            offset <= redirect_pc[OFFS_W-1:0];
            pc     <= redirect_pc;
        end else begin
            if (handshake) assert (legal);
            if (push) tail <= ptr_add(tail, 1);
            if (consume) begin
                head   <= ptr_add(head, int'(pops));
                offset <= sum[OFFS_W-1:0];
                pc     <= pc + IADDRW'(fetch.f_bytes_read);
            end
            count <= count + CNT_LW'(push) - pops;
        end
    end

    fetch_window_align u_align (
        .line0     (lines[0]),
        .line1     (lines[1]),
        .line2     (lines[2]),
        .offset    (offset),
        .win_bytes (win_bytes),
        .window    (fetch.f_instruction)
    );

    assign line.l_ready         = l_ready_i;
    assign fetch.f_valid        = (avail != 0);
    assign fetch.f_valid_bytes  = win_bytes;
    assign fetch.f_pc           = pc;
    assign fetch.f_branch_taken = (count != '0) && bt[head];
endmodule

// File: tb/tb_fetch_byte_queue.sv
module tb_fetch_byte_queue;
    import fetch_pkg::*;

    logic        clk = 1'b0;
    logic        reset;
    logic        flush;
    logic [31:0] redirect_pc;

    line_if  #(.IDATAW(128)) lif ();
    fetch_if #(.IADDRW(32))  fif ();

    fetch_byte_queue #(
        .IDATAW(128), .IADDRW(32), .DEPTH(4), .RESET_PC(32'h0)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .flush       (flush),
        .redirect_pc (redirect_pc),
        .line        (lif),
        .fetch       (fif)
    );

    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;

    // scoreboard: byte stream still owed to the decoder, one bt flag per line
    logic [7:0]  bq [$];
    bit          btq [$];
    int          mcount = 0;
    int          moff   = 0;
    logic [31:0] mpc    = 32'h0;

    task automatic chk(input string tag, input logic [255:0] act, input logic [255:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, act, exp);
        end
    endtask

    function automatic logic [127:0] mk_line(input logic [7:0] b);
        logic [127:0] l;
        for (int i = 0; i < 16; i++) l[8*i +: 8] = b + 8'(i);
        return l;
    endfunction

    function automatic int model_vb();
        return (bq.size() > 32) ? 32 : bq.size();
    endfunction

    task automatic check_outputs();
        logic [255:0] w;
        int           n;
        n = model_vb();
        w = '0;
        for (int i = 0; i < n; i++) w[8*i +: 8] = bq[i];
        chk("f_valid", fif.f_valid, (bq.size() != 0));
        chk("f_valid_bytes", fif.f_valid_bytes, n);
        chk("f_instruction", fif.f_instruction, w);
        chk("f_pc", fif.f_pc, mpc);
        chk("f_branch_taken", fif.f_branch_taken, (mcount != 0) ? btq[0] : 1'b0);
        chk("l_ready", lif.l_ready, (!reset && !flush && mcount < 4));
    endtask

    // one clock: drive at posedge+1, check at negedge, update scoreboard at posedge
    task automatic cycle(input bit lv, input logic [127:0] ld, input bit lbt,
                         input bit fr, input int nb, input bit fl, input logic [31:0] rp);
        bit do_push, do_pop;
        int start, sum, pops;
        lif.l_valid = lv; lif.l_data = ld; lif.l_branch_taken = lbt;
        fif.f_ready = fr; fif.f_bytes_read = 6'(nb);
        flush = fl; redirect_pc = rp;
        @(negedge clk);
        check_outputs();
        do_push = lv && !fl && (mcount < 4);
        do_pop  = fr && !fl && (bq.size() != 0);
        @(posedge clk);
        if (fl) begin
            bq.delete(); btq.delete();
            mcount = 0; moff = int'(rp[3:0]); mpc = rp;
        end else begin
            if (do_push) begin
                start = (mcount == 0) ? moff : 0;
                for (int i = start; i < 16; i++) bq.push_back(ld[8*i +: 8]);
                btq.push_back(lbt);
                mcount++;
            end
            if (do_pop) begin
                sum  = moff + nb;
                pops = sum / 16;
                for (int i = 0; i < nb; i++) void'(bq.pop_front());
                for (int i = 0; i < pops; i++) void'(btq.pop_front());
                mcount -= pops;
                moff = sum % 16;
                mpc  = mpc + 32'(nb);
            end
        end
        #1;
        lif.l_valid = 0; fif.f_ready = 0; fif.f_bytes_read = 0; flush = 0;
    endtask

    task automatic push_line(input logic [7:0] b, input bit lbt);
        cycle(1, mk_line(b), lbt, 0, 0, 0, 0);
    endtask

    task automatic read_bytes(input int nb);
        cycle(0, '0, 0, 1, nb, 0, 0);
    endtask

    initial begin
        reset = 1; flush = 0; redirect_pc = 0;
        lif.l_valid = 0; lif.l_data = '0; lif.l_branch_taken = 0;
        fif.f_ready = 0; fif.f_bytes_read = 0;
        #12;
        chk("rst_f_valid", fif.f_valid, 0);
        chk("rst_l_ready", lif.l_ready, 0);
        chk("rst_f_pc", fif.f_pc, 32'h0);
        chk("rst_f_valid_bytes", fif.f_valid_bytes, 0);
        chk("rst_f_instruction", fif.f_instruction, '0);
        chk("rst_f_branch_taken", fif.f_branch_taken, 0);
        @(posedge clk); #1; reset = 0;

        // two lines give a full 32-byte window
        push_line(8'h00, 1);
        push_line(8'h10, 0);
        chk("t1_vb", fif.f_valid_bytes, 32);
        chk("t1_b0", fif.f_instruction[7:0], 8'h00);
        chk("t1_b31", fif.f_instruction[255:248], 8'h1F);
        chk("t1_pc", fif.f_pc, 32'h0);
        chk("t1_bt", fif.f_branch_taken, 1);

        // partial reads crossing a line boundary
        read_bytes(5);
        read_bytes(13);
        chk("t2_pc", fif.f_pc, 32'h12);
        chk("t2_vb", fif.f_valid_bytes, 14);
        chk("t2_b0", fif.f_instruction[7:0], 8'h12);
        chk("t2_hi_zero", fif.f_instruction[255:112], '0);
        chk("t2_bt", fif.f_branch_taken, 0);

        // drain, fill to full, then a 32-byte read pops two lines while push is refused
        read_bytes(14);
        chk("t3_empty", fif.f_valid, 0);
        push_line(8'h20, 0);
        push_line(8'h30, 1);
        push_line(8'h40, 0);
        push_line(8'h50, 1);
        chk("t3_full_l_ready", lif.l_ready, 0);
        cycle(1, mk_line(8'h60), 0, 1, 32, 0, 0);
        chk("t3_vb", fif.f_valid_bytes, 32);
        chk("t3_b0", fif.f_instruction[7:0], 8'h40);
        chk("t3_b31", fif.f_instruction[255:248], 8'h5F);
        chk("t3_l_ready", lif.l_ready, 1);

        // flush to a mid-line PC; leading bytes of the first line are skipped
        cycle(0, '0, 0, 0, 0, 1, 32'h1007);
        push_line(8'hA0, 1);
        chk("t4_pc", fif.f_pc, 32'h1007);
        chk("t4_vb", fif.f_valid_bytes, 9);
        chk("t4_b0", fif.f_instruction[7:0], 8'hA7);

        // flush wins over a simultaneous push and read
        cycle(1, mk_line(8'hB0), 0, 1, 3, 1, 32'h2000);
        chk("t5_f_valid", fif.f_valid, 0);
        chk("t5_pc", fif.f_pc, 32'h2000);
        chk("t5_vb", fif.f_valid_bytes, 0);

        // asynchronous reset mid-stream
        push_line(8'hC0, 0);
        push_line(8'hD0, 1);
        push_line(8'hE0, 0);
        chk("t6_pre_vb", fif.f_valid_bytes, 32);
        #2 reset = 1;
        #1;
        chk("t6_f_valid", fif.f_valid, 0);
        chk("t6_l_ready", lif.l_ready, 0);
        chk("t6_pc", fif.f_pc, 32'h0);
        chk("t6_vb", fif.f_valid_bytes, 0);
        bq.delete(); btq.delete(); mcount = 0; moff = 0; mpc = 32'h0;
        @(posedge clk); #1; reset = 0;
        push_line(8'h70, 1);
        chk("t6_after_b0", fif.f_instruction[7:0], 8'h70);

        // random traffic with occasional flushes exercises pointer wrap
        for (int c = 0; c < 400; c++) begin
            int  vb, nb;
            bit  fl;
            vb = model_vb();
            nb = (vb == 0) ? 1 : int'($urandom_range(1, vb));
            fl = ($urandom_range(0, 24) == 0);
            cycle(1'($urandom), mk_line(8'($urandom)), 1'($urandom),
                  1'($urandom), nb, fl, $urandom);
        end
        cycle(0, '0, 0, 0, 0, 0, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
